// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one 4-bit multiplier core among NUM_REQ requesters.
module mult_rr_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [4*NUM_REQ-1:0] a_i,
  input  logic [4*NUM_REQ-1:0] b_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [7:0]           y_o,
  output logic                 err_o,
  output logic [3:0]           A_o,
  output logic [3:0]           B_o,
  output logic                 enable_o,
  input  logic [7:0]           Y_i,
  input  logic                 fim_i
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] req_q, gnt_q, gnt_d, done_q, done_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d, sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] y_q, y_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic en_q, en_d, err_q, err_d;
  // Scan downward so the set bit closest above the pointer is the last to win.
  always_comb begin
    sel = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_q) + i;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (req_q[PW'(j)]) sel = PW'(j);
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    done_d = '0;
    err_d = 1'b0;
    y_d = y_q;
    a_d = a_q;
    b_d = b_q;
    en_d = en_q;
    case (state_q)
      IDLE: if (|req_q) begin
        a_d = a_i[4*sel +: 4];
        b_d = b_i[4*sel +: 4];
        g_d = sel;
        gnt_d = NUM_REQ'(1) << sel;
        en_d = 1'b1;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (fim_i || cnt_q == CW'(TIMEOUT - 1)) begin
          y_d = fim_i ? Y_i : 8'd0;
          err_d = !fim_i;
          done_d = gnt_q;
          en_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: if (!fim_i) begin
        gnt_d = '0;
        ptr_d = g_q == PW'(NUM_REQ - 1) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q <= '0;
      ptr_q <= '0;
      g_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
      y_q <= '0;
      a_q <= '0;
      b_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_i;
      ptr_q <= ptr_d;
      g_q <= g_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      err_q <= err_d;
      y_q <= y_d;
      a_q <= a_d;
      b_q <= b_d;
      en_q <= en_d;
    end
  end
  assign gnt_o = gnt_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign y_o = y_q;
  assign A_o = a_q;
  assign B_o = b_q;
  assign enable_o = en_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: scoreboard bench with a behavioural multiplier core model.
module tb_mult_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_i = '0;
  logic [7:0] a_i = '0, b_i = '0;
  logic [1:0] gnt_o, done_o;
  logic [7:0] y_o, Y_i;
  logic err_o, enable_o, fim_i;
  logic [3:0] A_o, B_o;
  typedef struct {int idx; logic [7:0] y; logic err;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int m_cnt = 0, sticky_cnt = 0, fim_dly = 4;
  bit fim_on = 1'b1, sticky_mode = 1'b0;

  mult_rr_scheduler #(.NUM_REQ(2), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .gnt_o(gnt_o), .done_o(done_o), .y_o(y_o), .err_o(err_o),
    .A_o(A_o), .B_o(B_o), .enable_o(enable_o), .Y_i(Y_i), .fim_i(fim_i)
  );

  always #5 clk = ~clk;

  // Core model: fim rises fim_dly cycles after enable, optionally held high after done.
  always @(posedge clk) begin
    m_cnt <= enable_o ? m_cnt + 1 : 0;
    if (sticky_mode && done_o != 0) sticky_cnt <= 10;
    else if (sticky_cnt != 0) sticky_cnt <= sticky_cnt - 1;
  end
  assign fim_i = fim_on && (m_cnt >= fim_dly || sticky_cnt != 0);
  assign Y_i = {4'd0, A_o} * {4'd0, B_o};

  always @(negedge clk) begin
    if (done_o != 0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: done=%b y=%0d err=%b", done_o, y_o, err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done_o !== (2'b01 << e.idx) || y_o !== e.y || err_o !== e.err) begin
          miscompares++;
          $display("FAIL completion: done=%b y=%0d err=%b, want done=%b y=%0d err=%b",
                   done_o, y_o, err_o, 2'b01 << e.idx, e.y, e.err);
        end
      end
    end else if (err_o === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL err_without_done: err=%b want 0", err_o);
    end
  end

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (enable_o === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      req_i &= ~done_o;
      if (req_i == 0 && gnt_o === 2'b00 && enable_o === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({gnt_o, done_o, y_o, err_o, A_o, B_o, enable_o} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_state: gnt=%b done=%b y=%0d err=%b A=%0d B=%0d en=%b, want all 0",
               gnt_o, done_o, y_o, err_o, A_o, B_o, enable_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_simultaneous;
    bit ok;
    a_i = {4'd15, 4'd2}; b_i = {4'd15, 4'd7};
    sb.push_back('{0, 8'd14, 1'b0});
    sb.push_back('{1, 8'd225, 1'b0});
    req_i = 2'b11;
    wait_en(ok);
    vectors++;
    if (!ok || gnt_o !== 2'b01) begin
      miscompares++; $display("FAIL simul_first_grant: gnt=%b want 01", gnt_o);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL simul_idle: timed out=%b want 0", !ok); end
    a_i = {4'd1, 4'd6}; b_i = {4'd9, 4'd3};
    sb.push_back('{0, 8'd18, 1'b0});
    sb.push_back('{1, 8'd9, 1'b0});
    req_i = 2'b11;
    wait_en(ok);
    vectors++;
    if (!ok || gnt_o !== 2'b01) begin
      miscompares++; $display("FAIL simul_pointer_wrap: gnt=%b want 01", gnt_o);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL simul_idle2: timed out=%b want 0", !ok); end
  endtask

  task automatic test_single;
    bit ok;
    int en;
    a_i = {4'd0, 4'd3}; b_i = {4'd0, 4'd5};
    sb.push_back('{0, 8'd15, 1'b0});
    @(negedge clk);
    req_i = 2'b01;
    @(negedge clk);
    vectors++;
    if (enable_o !== 1'b0) begin miscompares++; $display("FAIL start_latency_early: en=%b want 0", enable_o); end
    @(negedge clk);
    vectors++;
    if (enable_o !== 1'b1 || gnt_o !== 2'b01 || A_o !== 4'd3 || B_o !== 4'd5) begin
      miscompares++;
      $display("FAIL single_start: en=%b gnt=%b A=%0d B=%0d want 1 01 3 5", enable_o, gnt_o, A_o, B_o);
    end
    en = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (enable_o === 1'b1) en++;
      if (done_o != 0) break;
    end
    req_i = 2'b00;
    vectors++;
    if (en != 5) begin miscompares++; $display("FAIL single_enable_len: %0d cycles want 5", en); end
    @(negedge clk);
    vectors++;
    if (done_o !== 2'b00 || y_o !== 8'd15) begin
      miscompares++; $display("FAIL single_done_pulse: done=%b y=%0d want 00 15", done_o, y_o);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_idle: timed out=%b want 0", !ok); end
  endtask

  task automatic test_withdraw;
    bit ok;
    a_i = {4'd9, 4'd0}; b_i = {4'd13, 4'd0};
    sb.push_back('{1, 8'd117, 1'b0});
    req_i = 2'b10;
    wait_en(ok);
    @(negedge clk);
    a_i = 8'hff; b_i = 8'hff;
    req_i = 2'b00;
    vectors++;
    if (!ok || A_o !== 4'd9 || B_o !== 4'd13) begin
      miscompares++; $display("FAIL withdraw_operands: A=%0d B=%0d want 9 13", A_o, B_o);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL withdraw_idle: timed out=%b want 0", !ok); end
  endtask

  task automatic run_long(input logic [7:0] y, input logic err, input string name);
    bit ok;
    int en;
    sb.push_back('{0, y, err});
    req_i = 2'b01;
    wait_en(ok);
    en = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (enable_o === 1'b1) en++;
      if (done_o != 0) break;
    end
    req_i = 2'b00;
    vectors++;
    if (!ok || en != 8 || enable_o !== 1'b0) begin
      miscompares++; $display("FAIL %s_len: %0d cycles en=%b want 8 0", name, en, enable_o);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    fim_on = 1'b0;
    a_i = {4'd0, 4'd7}; b_i = {4'd0, 4'd7};
    run_long(8'd0, 1'b1, "timeout");
    fim_on = 1'b1;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL timeout_idle: timed out=%b want 0", !ok); end
  endtask

  task automatic test_boundary;
    bit ok;
    fim_dly = 7;
    a_i = {4'd0, 4'd4}; b_i = {4'd0, 4'd11};
    run_long(8'd44, 1'b0, "boundary");
    wait_idle(ok);
    fim_dly = 4;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL boundary_idle: timed out=%b want 0", !ok); end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    a_i = {4'd7, 4'd5}; b_i = {4'd8, 4'd5};
    req_i = 2'b11;
    wait_en(ok);
    vectors++;
    if (!ok || gnt_o !== 2'b10) begin miscompares++; $display("FAIL rr_pointer: gnt=%b want 10", gnt_o); end
    @(negedge clk);
    rst = 1'b1;
    req_i = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({enable_o, gnt_o, y_o, done_o, A_o} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run: en=%b gnt=%b y=%0d done=%b A=%0d want all 0", enable_o, gnt_o, y_o, done_o, A_o);
    end
    sb.push_back('{0, 8'd25, 1'b0});
    sb.push_back('{1, 8'd56, 1'b0});
    req_i = 2'b11;
    wait_en(ok);
    vectors++;
    if (!ok || gnt_o !== 2'b01) begin miscompares++; $display("FAIL reset_pointer: gnt=%b want 01", gnt_o); end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL reset_idle: timed out=%b want 0", !ok); end
  endtask

  task automatic test_sticky_fim;
    bit ok, bad;
    int n;
    a_i = {4'd10, 4'd12}; b_i = {4'd3, 4'd12};
    sb.push_back('{0, 8'd144, 1'b0});
    sticky_mode = 1'b1;
    req_i = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) begin ok = 1'b1; break; end
    end
    req_i = 2'b10;
    sb.push_back('{1, 8'd30, 1'b0});
    @(negedge clk);
    sticky_mode = 1'b0;
    bad = 1'b0;
    n = 0;
    while (fim_i === 1'b1 && n < 40) begin
      if (gnt_o !== 2'b01 || enable_o !== 1'b0) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (!ok || bad || n != 10) begin
      miscompares++; $display("FAIL sticky_hold: bad=%b fim_cycles=%0d want 0 10", bad, n);
    end
    vectors++;
    if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL sticky_drain_last: gnt=%b want 01", gnt_o); end
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00 || enable_o !== 1'b0) begin
      miscompares++; $display("FAIL sticky_idle_entry: gnt=%b en=%b want 00 0", gnt_o, enable_o);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL sticky_idle: timed out=%b want 0", !ok); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_withdraw();
    test_timeout();
    test_boundary();
    test_reset_mid_run();
    test_sticky_fim();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one 4-bit multiplier core (A/B operands, enable start, 8-bit Y result, fim done flag) between NUM_REQ independent requesters.
- Sequences each operation: arbitrate, latch operands, assert enable, wait for fim, capture Y, wait for fim release.
- Returns the result to the winning requester with a one-cycle done pulse.
- Sits between requester logic (Wishbone-mapped register blocks or local FSMs) and the multiplier core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, max cycles in RUN waiting for fim_i before aborting (>=2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  NUM_REQ  per-requester request level; held until own done_o bit pulses
- a_i  in  4*NUM_REQ  operand A, requester k at bits [4k+3:4k]
- b_i  in  4*NUM_REQ  operand B, same packing
- gnt_o  out  NUM_REQ  one-hot grant, high from RUN entry through DRAIN exit
- done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
- y_o  out  8  result of last completed operation; valid when any done_o bit is high, held until next completion
- err_o  out  1  one-cycle pulse coincident with done_o when the operation timed out
- A_o  out  4  multiplier operand A
- B_o  out  4  multiplier operand B
- enable_o  out  1  multiplier start/run level
- Y_i  in  8  multiplier product
- fim_i  in  1  multiplier finished flag

Behaviour:
- Reset (rst_i=1 at an edge) forces the following, regardless of state, including mid-operation:
  - state=IDLE, gnt_o=0, done_o=0, err_o=0, y_o=0, A_o=0, B_o=0, enable_o=0;
  - round-robin pointer=0; timeout counter=0.
- FSM states: IDLE, RUN, DRAIN. All outputs are registered.
- IDLE:
  - If any req_i bit is set, select the first set bit searching upward from the pointer, with modulo-NUM_REQ wrap.
  - Next edge: latch that requester's a/b into A_o/B_o, set gnt_o one-hot, enable_o=1, counter=0, go to RUN.
  - Start latency: req_i sampled at edge n means enable_o is high after edge n+1.
- RUN:
  - enable_o held 1; A_o/B_o held stable; counter increments each cycle.
  - Exit condition is evaluated in this order:
    - fim_i=1: next edge y_o<=Y_i, done_o[g]=1 for one cycle, enable_o=0, go to DRAIN.
    - else if counter==TIMEOUT-1: next edge y_o<=0, done_o[g]=1, err_o=1 (both one cycle), enable_o=0, go to DRAIN.
  - fim_i=1 on the same cycle the counter hits TIMEOUT-1 counts as success: no err_o.
- DRAIN:
  - enable_o=0; gnt_o still held.
  - When fim_i=0: next edge gnt_o=0, pointer=(g+1) mod NUM_REQ, go to IDLE.
  - If fim_i stays high, remain in DRAIN indefinitely. No new grant is issued.
- The minimum gap between consecutive operations is one IDLE cycle. Back-to-back requests are not pipelined.
- Dropping req_i while granted does not abort the operation: it completes and done_o still pulses.
- A requester whose req_i is still high in the IDLE cycle after its own done is treated as a new request. Because the pointer has advanced past it, any other pending requester wins first.
- Fairness: with all requests continuously asserted, grants rotate 0,1,…,NUM_REQ-1,0,…
- a_i/b_i are sampled only on the IDLE→RUN edge; later changes have no effect on the current operation.
- Product arithmetic is performed by the core. y_o is an unmodified copy of Y_i (unsigned 8-bit).

Test Plan:
- Single op: req_i=01, a=3, b=5; core model raises fim 4 cycles after enable. Required: gnt_o=01, enable_o high for 5 cycles, done_o=01 one cycle, y_o=15, err_o=0, then back to IDLE.
- Simultaneous requests: req_i=11, a0=2, b0=7, a1=15, b1=15, both held until own done. Required: first grant 01 with y_o=14; after drain, grant 10 with y_o=225; the pointer then favours requester 0 again.
- Timeout: TIMEOUT=8, fim never asserted. Required: done_o pulses exactly 8 cycles after enable rises, err_o=1 with it, y_o=0, enable_o=0 next cycle.
- Sticky fim: fim held high for 10 cycles after done. Required: gnt_o held, no new enable_o while fim high; IDLE is entered one cycle after fim falls.
- Reset mid-RUN: assert rst_i for 1 cycle at cycle 2 of RUN. Required: enable_o, gnt_o, y_o all 0 after that edge; no done_o; the next grant starts from requester 0.
- Request withdrawn: req_i[1] dropped after 1 cycle of RUN. Required: operation still completes, done_o=10, correct y_o.
